demux_registrado: RTL and testbench

Parametrised 1-to-CANALES demultiplexer with a one-word output register and valid/ready handshake on every channel. It routes each accepted input word to the channel chosen by `selector` and holds it until that channel's consumer (typically a FIFO write port) takes it. It sits between the serial data source and the per-lane FIFOs, replacing the combinational 4-way demux with a back-pressure-aware, registered version.

---
 rtl/demux_registrado.sv | 76 +++++++
 tb/tb_demux_registrado.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_registrado.sv
// demux_registrado: registered 1-to-CANALES demux with per-channel valid/ready; define DEMUX_CONTEO_EN for per-channel accept counters
module demux_registrado #(
  parameter int DATA_BITS = 4,
  parameter int CANALES = 4,
  parameter int COUNT_BITS = 8,
  localparam int SEL_BITS = $clog2(CANALES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enb,
  input  logic [DATA_BITS-1:0]          entrada,
  input  logic [SEL_BITS-1:0]           selector,
  input  logic                          valid_entrada,
  output logic                          listo_entrada,
  output logic [CANALES*DATA_BITS-1:0]  salidas,
  output logic [CANALES-1:0]            valid_salida,
  input  logic [CANALES-1:0]            listo_salida,
`ifdef DEMUX_CONTEO_EN
  output logic [CANALES*COUNT_BITS-1:0] contadores,
`endif
  output logic                          error_selector
);
  logic [DATA_BITS-1:0] r_dato [CANALES];
  logic [CANALES-1:0]   r_valid;
  logic                 r_err;
  logic [CANALES-1:0]   w_match;
  logic [CANALES-1:0]   w_bloq;
  logic [CANALES-1:0]   w_carga;
  logic                 w_sel_ok;
  logic                 w_acepta;
  if (CANALES < 2 || COUNT_BITS < 1) begin : g_param_chk
    $error("demux_registrado: CANALES must be >= 2 and COUNT_BITS >= 1");
  end
  // decode selector; a full channel whose consumer is not ready blocks input
  always_comb begin
    w_match = '0;
    w_bloq  = '0;
    salidas = '0;
    for (int i = 0; i < CANALES; i++) begin
      w_match[i] = selector == SEL_BITS'(i);
      w_bloq[i]  = w_match[i] && r_valid[i] && !listo_salida[i];
      salidas[i*DATA_BITS +: DATA_BITS] = r_dato[i];
    end
  end
  assign w_sel_ok       = |w_match;
  assign listo_entrada  = enb && !(|w_bloq);
  assign w_acepta       = valid_entrada && listo_entrada;
  assign w_carga        = w_acepta ? w_match : '0;
  assign valid_salida   = r_valid;
  assign error_selector = r_err;
  // load on accept, drain on consumer handshake; a load in the drain cycle keeps the channel full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CANALES; i++) r_dato[i] <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < CANALES; i++) if (w_carga[i]) r_dato[i] <= entrada;
      r_valid <= w_carga | (r_valid & ~listo_salida);
      r_err   <= w_acepta && !w_sel_ok;
    end
  end
`ifdef DEMUX_CONTEO_EN
  logic [COUNT_BITS-1:0] r_cont [CANALES];
  // count words accepted per channel, wrapping; dropped words never match a channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < CANALES; i++) r_cont[i] <= '0;
    else for (int i = 0; i < CANALES; i++) if (w_carga[i]) r_cont[i] <= r_cont[i] + COUNT_BITS'(1);
  end
  // flatten counters onto the output bus
  always_comb begin
    contadores = '0;
    for (int i = 0; i < CANALES; i++) contadores[i*COUNT_BITS +: COUNT_BITS] = r_cont[i];
  end
`endif
endmodule

// File: tb/tb_demux_registrado.sv
// tb_demux_registrado: checks a 4-channel and a 3-channel instance against a behavioural model
module tb_demux_registrado;
  logic clk = 1'b0;
  logic reset, enb, vin;
  logic [3:0] ent, ls;
  logic [1:0] sel;
  logic le4, le3, e4, e3;
  logic [15:0] s4;
  logic [11:0] s3;
  logic [3:0] v4;
  logic [2:0] v3;
`ifdef DEMUX_CONTEO_EN
  logic [15:0] c4;
  logic [11:0] c3;
`endif
  int nchk = 0;
  int nerr = 0;
  int nch [2] = '{4, 3};

  always #5 clk = ~clk;

  demux_registrado #(.DATA_BITS(4), .CANALES(4), .COUNT_BITS(4)) u4 (
    .clk(clk), .reset(reset), .enb(enb), .entrada(ent), .selector(sel),
    .valid_entrada(vin), .listo_entrada(le4), .salidas(s4), .valid_salida(v4),
    .listo_salida(ls),
`ifdef DEMUX_CONTEO_EN
    .contadores(c4),
`endif
    .error_selector(e4));

  demux_registrado #(.DATA_BITS(4), .CANALES(3), .COUNT_BITS(4)) u3 (
    .clk(clk), .reset(reset), .enb(enb), .entrada(ent), .selector(sel),
    .valid_entrada(vin), .listo_entrada(le3), .salidas(s3), .valid_salida(v3),
    .listo_salida(ls[2:0]),
`ifdef DEMUX_CONTEO_EN
    .contadores(c3),
`endif
    .error_selector(e3));

  logic dle [2];
  logic de [2];
  logic dv [2][4];
  logic [3:0] dd [2][4];
  logic [3:0] dc [2][4];
  always_comb begin
    dle[0] = le4; dle[1] = le3;
    de[0] = e4; de[1] = e3;
    for (int k = 0; k < 4; k++) begin
      dv[0][k] = v4[k]; dd[0][k] = s4[k*4 +: 4];
      dv[1][k] = 1'b0; dd[1][k] = 4'h0;
      dc[0][k] = 4'h0; dc[1][k] = 4'h0;
    end
    for (int k = 0; k < 3; k++) begin
      dv[1][k] = v3[k]; dd[1][k] = s3[k*4 +: 4];
    end
`ifdef DEMUX_CONTEO_EN
    for (int k = 0; k < 4; k++) dc[0][k] = c4[k*4 +: 4];
    for (int k = 0; k < 3; k++) dc[1][k] = c3[k*4 +: 4];
`endif
  end

  logic mv [2][4];
  logic [3:0] md [2][4];
  logic [3:0] mc [2][4];
  logic me [2];

  function automatic logic mrdy(input int u);
    return enb && (int'(sel) >= nch[u] || !mv[u][sel] || ls[sel]);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int u = 0; u < 2; u++) begin
        me[u] <= 1'b0;
        for (int k = 0; k < 4; k++) begin
          mv[u][k] <= 1'b0; md[u][k] <= 4'h0; mc[u][k] <= 4'h0;
        end
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        for (int k = 0; k < nch[u]; k++) begin
          if (vin && mrdy(u) && int'(sel) == k) begin
            mv[u][k] <= 1'b1; md[u][k] <= ent; mc[u][k] <= mc[u][k] + 4'd1;
          end else if (ls[k]) mv[u][k] <= 1'b0;
        end
        me[u] <= vin && mrdy(u) && int'(sel) >= nch[u];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    #3;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d listo_entrada", u), 32'(dle[u]), 32'(mrdy(u)));
      chk($sformatf("u%0d error_selector", u), 32'(de[u]), 32'(me[u]));
      for (int k = 0; k < nch[u]; k++) begin
        chk($sformatf("u%0d valid[%0d]", u, k), 32'(dv[u][k]), 32'(mv[u][k]));
        chk($sformatf("u%0d data[%0d]", u, k), 32'(dd[u][k]), 32'(md[u][k]));
`ifdef DEMUX_CONTEO_EN
        chk($sformatf("u%0d count[%0d]", u, k), 32'(dc[u][k]), 32'(mc[u][k]));
`endif
      end
    end
  end

  task automatic setin(input logic en_, input logic v_, input logic [1:0] s_, input logic [3:0] e_, input logic [3:0] l_);
    enb = en_; vin = v_; sel = s_; ent = e_; ls = l_;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cyc(input logic en_, input logic v_, input logic [1:0] s_, input logic [3:0] e_, input logic [3:0] l_);
    setin(en_, v_, s_, e_, l_);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    setin(1'b1, 1'b0, 2'd0, 4'h0, 4'hF);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    chk("reset valid", 32'(v4), 0);
    chk("reset salidas", 32'(s4), 0);
    chk("reset error", 32'(e4), 0);
    chk("reset listo", 32'(le4), 1);
    cyc(1, 1, 2'd0, 4'hA, 4'hF);
    chk("seq ch0 data", 32'(s4[3:0]), 32'hA);
    chk("seq ch0 valid", 32'(v4), 32'b0001);
    cyc(1, 1, 2'd1, 4'h5, 4'hF);
    chk("seq ch1 data", 32'(s4[7:4]), 32'h5);
    chk("seq ch1 valid", 32'(v4), 32'b0010);
    cyc(1, 1, 2'd2, 4'hC, 4'hF);
    chk("seq ch2 data", 32'(s4[11:8]), 32'hC);
    chk("seq ch2 valid", 32'(v4), 32'b0100);
    cyc(1, 1, 2'd3, 4'h3, 4'hF);
    chk("seq ch3 data", 32'(s4[15:12]), 32'h3);
    chk("seq ch3 valid", 32'(v4), 32'b1000);
    chk("u3 sel3 error", 32'(e3), 1);
    chk("u3 sel3 no valid", 32'(v3), 0);
    cyc(1, 0, 2'd0, 4'h0, 4'hF);
    chk("seq drained", 32'(v4), 0);
    chk("u3 error one cycle", 32'(e3), 0);
    cyc(1, 1, 2'd2, 4'h7, 4'b1011);
    chk("bp hold 7", 32'(s4[11:8]), 32'h7);
    setin(1, 1, 2'd2, 4'h9, 4'b1011);
    #2 chk("bp listo low", 32'(le4), 0);
    tick();
    chk("bp still 7", 32'(s4[11:8]), 32'h7);
    chk("bp valid held", 32'(v4), 32'b0100);
    cyc(1, 1, 2'd2, 4'h9, 4'hF);
    chk("bp no bubble", 32'(v4[2]), 1);
    chk("bp loaded 9", 32'(s4[11:8]), 32'h9);
    cyc(1, 0, 2'd0, 4'h0, 4'hF);
    cyc(1, 1, 2'd3, 4'hF, 4'hF);
    chk("oor error pulse", 32'(e3), 1);
    chk("oor no valid", 32'(v3), 0);
    cyc(1, 0, 2'd0, 4'h0, 4'hF);
    chk("oor error clears", 32'(e3), 0);
    cyc(1, 1, 2'd1, 4'h6, 4'b1101);
    chk("enb fill ch1", 32'(v4), 32'b0010);
    setin(0, 1, 2'd1, 4'h8, 4'hF);
    #2 chk("enb0 listo", 32'(le4), 0);
    tick();
    chk("enb0 drains", 32'(v4[1]), 0);
    chk("enb0 keeps data", 32'(s4[7:4]), 32'h6);
    cyc(1, 1, 2'd0, 4'h1, 4'h0);
    cyc(1, 1, 2'd1, 4'h2, 4'h0);
    cyc(1, 1, 2'd2, 4'h3, 4'h0);
    chk("pre-reset full", 32'(v4), 32'b0111);
    setin(1, 0, 2'd0, 4'h0, 4'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset v4", 32'(v4), 0);
    chk("async reset s4", 32'(s4), 0);
    chk("async reset v3", 32'(v3), 0);
    chk("async reset s3", 32'(s3), 0);
    tick();
    reset = 1'b0;
    setin(1, 0, 2'd0, 4'h0, 4'hF);
    tick();
`ifdef DEMUX_CONTEO_EN
    for (int i = 0; i < 17; i++) cyc(1, 1, 2'd0, 4'(i), 4'hF);
    cyc(1, 0, 2'd0, 4'h0, 4'hF);
    chk("count wrap u4", 32'(c4), 32'h0001);
    chk("count wrap u3", 32'(c3), 32'h001);
`endif
    repeat (400)
      cyc($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
